sort_result_reader: RTL and testbench

- Read-side counterpart to the datapath's address/data write port. The datapath is loaded one 4-bit value per address; this block drains the four result registers back out.
- On a start pulse it snapshots first_reg..fourth_reg. It then streams the four values one per transfer over a valid/ready handshake, tagged with their address.
- It sits between the datapath outputs and the downstream consumer (display scanner or host).

---
 rtl/sort_pkg.sv | 14 +
 rtl/sort_result_reader_if.sv | 26 ++
 rtl/sort_result_reader_reg.sv | 24 ++
 rtl/sort_result_reader.sv | 110 +++++++++++
 tb/tb_sort_result_reader.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/sort_pkg.sv
// Shared types and constants for the sort datapath readout logic.
package sort_pkg;

  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned ADDR_W   = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DONE
  } reader_state_t;

endpackage

// File: rtl/sort_result_reader_if.sv
// Valid/ready element stream carrying one result value plus its address.
interface sort_result_reader_if #(
  parameter int unsigned WIDTH = 4
);
  import sort_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output out_valid,
    output out_data,
    output out_addr,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_addr,
    output out_ready
  );

endinterface

// File: rtl/sort_result_reader_reg.sv
// Enabled register with asynchronous active-low clear; holds one snapshot value.
module sort_result_reader_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sort_result_reader.sv
// Snapshots the four datapath result registers on start and streams them out,
// one element per valid/ready transfer, tagged with the register address.
module sort_result_reader
  import sort_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter bit          REVERSE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     first_reg,
  input  logic [WIDTH-1:0]     second_reg,
  input  logic [WIDTH-1:0]     third_reg,
  input  logic [WIDTH-1:0]     fourth_reg,
  output logic                 busy,
  output logic                 done,
  sort_result_reader_if.master out_bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] START_IDX  = REVERSE ? ADDR_W'(NUM_REGS - 1) : '0;
  localparam logic [CNT_W-1:0]  LAST_COUNT = CNT_W'(NUM_REGS - 1);

  reader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load_en;
  logic              valid;
  logic              xfer;

  logic [WIDTH-1:0] reg_in [NUM_REGS];
  logic [WIDTH-1:0] snap   [NUM_REGS];

  assign reg_in[0] = first_reg;
  assign reg_in[1] = second_reg;
  assign reg_in[2] = third_reg;
  assign reg_in[3] = fourth_reg;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_snap
    sort_result_reader_reg #(
      .WIDTH (WIDTH)
    ) u_snap_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (load_en),
      .d     (reg_in[i]),
      .q     (snap[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid = (state_q == STREAM);
  assign xfer  = valid && out_bus.out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    load_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_en = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        idx_d   = START_IDX;
        cnt_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        // Termination is on the transfer count; the 2-bit index simply wraps.
        if (xfer) begin
          idx_d = REVERSE ? idx_q - 1'b1 : idx_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_COUNT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode the state directly so an async reset drops them at once.
  assign out_bus.out_valid = valid;
  assign out_bus.out_data  = snap[idx_q];
  assign out_bus.out_addr  = idx_q;
  assign busy              = (state_q == LOAD) || (state_q == STREAM);
  assign done              = (state_q == DONE);

endmodule

// File: tb/tb_sort_result_reader.sv
// Directed bench for sort_result_reader: forward and reversed instances share stimulus.
module tb_sort_result_reader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] first_reg, second_reg, third_reg, fourth_reg;
  logic       ready;
  logic       busy0, done0, busy1, done1;

  int n_checks = 0;
  int n_pass   = 0;
  int xfer0    = 0;

  sort_result_reader_if #(.WIDTH(4)) bus0 ();
  sort_result_reader_if #(.WIDTH(4)) bus1 ();

  assign bus0.out_ready = ready;
  assign bus1.out_ready = ready;

  sort_result_reader #(.WIDTH(4), .REVERSE(1'b0)) u_fwd (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .first_reg  (first_reg),
    .second_reg (second_reg),
    .third_reg  (third_reg),
    .fourth_reg (fourth_reg),
    .busy       (busy0),
    .done       (done0),
    .out_bus    (bus0.master)
  );

  sort_result_reader #(.WIDTH(4), .REVERSE(1'b1)) u_rev (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .first_reg  (first_reg),
    .second_reg (second_reg),
    .third_reg  (third_reg),
    .fourth_reg (fourth_reg),
    .busy       (busy1),
    .done       (done1),
    .out_bus    (bus1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] regs;      // {fourth, third, second, first}
    bit          rev;       // check the REVERSE=1 instance
    logic [15:0] exp_data;  // emission i at [4i+:4]
    logic [7:0]  exp_addr;  // emission i at [2i+:2]
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one edge and settle; counts forward-instance transfers at that edge.
  task automatic tick();
    if (bus0.out_valid && ready) xfer0++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_regs(input logic [15:0] r);
    first_reg  = r[3:0];
    second_reg = r[7:4];
    third_reg  = r[11:8];
    fourth_reg = r[15:12];
  endtask

  task automatic run_vec(input vec_t v);
    set_regs(v.regs);
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_busy", v.rev ? busy1 : busy0, 1);
    check("load_valid", v.rev ? bus1.out_valid : bus0.out_valid, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("elem_valid", v.rev ? bus1.out_valid : bus0.out_valid, 1);
      check("elem_addr", v.rev ? bus1.out_addr : bus0.out_addr, v.exp_addr[2*i +: 2]);
      check("elem_data", v.rev ? bus1.out_data : bus0.out_data, v.exp_data[4*i +: 4]);
      tick();
    end
    check("done_pulse", v.rev ? done1 : done0, 1);
    check("done_busy", v.rev ? busy1 : busy0, 0);
    check("done_valid", v.rev ? bus1.out_valid : bus0.out_valid, 0);
    tick();
    check("done_clear", v.rev ? done1 : done0, 0);
    check("idle_busy", v.rev ? busy1 : busy0, 0);
  endtask

  initial begin
    vecs[0] = '{regs: 16'hF951, rev: 1'b0, exp_data: 16'hF951, exp_addr: 8'hE4};
    vecs[1] = '{regs: 16'h8642, rev: 1'b1, exp_data: 16'h2468, exp_addr: 8'h1B};
    vecs[2] = '{regs: 16'h730A, rev: 1'b0, exp_data: 16'h730A, exp_addr: 8'hE4};
    vecs[3] = '{regs: 16'h730A, rev: 1'b1, exp_data: 16'hA037, exp_addr: 8'h1B};

    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    set_regs(16'hC193);
    #12;
    check("rst_valid", bus0.out_valid, 0);
    check("rst_data", bus0.out_data, 0);
    check("rst_addr", bus0.out_addr, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_rev_addr", bus1.out_addr, 0);
    rst_n = 1'b1;

    // Idle without start.
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_quiet", {bus0.out_valid, busy0, done0, bus1.out_valid, busy1, done1}, 0);
    end

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Backpressure on the second element.
    set_regs(16'hF951);
    ready = 1'b1;
    xfer0 = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("bp_e0", {bus0.out_addr, bus0.out_data}, {2'd0, 4'h1});
    tick();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold", {bus0.out_valid, bus0.out_addr, bus0.out_data}, {1'b1, 2'd1, 4'h5});
      tick();
    end
    ready = 1'b1;
    check("bp_e1", {bus0.out_valid, bus0.out_addr, bus0.out_data}, {1'b1, 2'd1, 4'h5});
    tick();
    check("bp_e2", {bus0.out_valid, bus0.out_addr, bus0.out_data}, {1'b1, 2'd2, 4'h9});
    tick();
    check("bp_e3", {bus0.out_valid, bus0.out_addr, bus0.out_data}, {1'b1, 2'd3, 4'hF});
    tick();
    check("bp_done", done0, 1);
    check("bp_xfers", xfer0, 4);
    tick();

    // Snapshot isolation and start ignored mid-stream.
    set_regs(16'hF951);
    start = 1'b1;
    tick();
    start = 1'b0;
    set_regs(16'h0000);
    tick();
    check("iso_e0", {bus0.out_addr, bus0.out_data}, {2'd0, 4'h1});
    tick();
    check("iso_e1", {bus0.out_addr, bus0.out_data}, {2'd1, 4'h5});
    start = 1'b1;
    tick();
    start = 1'b0;
    check("iso_e2", {bus0.out_addr, bus0.out_data}, {2'd2, 4'h9});
    tick();
    check("iso_e3", {bus0.out_addr, bus0.out_data}, {2'd3, 4'hF});
    tick();
    check("iso_done", done0, 1);
    tick();
    tick();
    check("iso_no_restart", {busy0, bus0.out_valid}, 0);

    // Async reset after the second transfer, between edges.
    set_regs(16'hF951);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("ar_pre", {bus0.out_valid, bus0.out_addr, busy0}, {1'b1, 2'd2, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_drop", {bus0.out_valid, busy0, done0, bus1.out_valid, busy1, done1}, 0);
    check("ar_data", bus0.out_data, 0);
    tick();
    tick();
    check("ar_no_done", {done0, done1}, 0);
    #2;
    rst_n = 1'b1;
    tick();
    check("ar_idle", {bus0.out_valid, busy0, done0}, 0);
    run_vec(vecs[0]);
    run_vec(vecs[1]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
